des_round_merge: RTL
====================

DES_ROUND_MERGE -- requirements
Module: des_round_merge

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL have: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have: start  in  1  one-cycle pulse; loads l_in/r_in and begins 16 rounds.
REQ-004 SHALL have: l_in, r_in  in  32 each  post-IP halves L0, R0; bit 32 = DES bit 1.
REQ-005 SHALL have: sbox_out  in  32  S1..S8 outputs concatenated, S1 in [32:29], S8 in [4:1].
REQ-006 SHALL have: sbox_finish  in  8  finish flags of S1..S8; bit 8 = S1.
REQ-007 SHALL have: sbox_select  out  1  drives all eight S-box select inputs.
REQ-008 SHALL have: r_cur  out  32  current R, feeds the upstream expansion/key-mix stage.
REQ-009 SHALL have: round  out  4  rounds completed, 0..15; wraps to 0 after round 16.
REQ-010 SHALL have: preout  out  64  {R16, L16}, valid when done is high.
REQ-011 SHALL have: busy  out  1  high from accepted start until done; done  out  1  one-cycle completion pulse.

Function
REQ-012 SHALL implement FSM IDLE -> ISSUE -> WAIT -> MERGE -> (ISSUE | FINISH) -> IDLE.
REQ-013 IDLE: start=1 SHALL load L<=l_in, R<=r_in, round<=0, busy<=1, go to ISSUE.
REQ-014 start SHALL be ignored in every state except IDLE.
REQ-015 ISSUE: sbox_select SHALL be 1 for exactly this one cycle; next state WAIT.
REQ-016 WAIT: all eight sbox_finish = 1 SHALL capture sbox_out and go to MERGE; otherwise SHALL return to ISSUE (re-issue).
REQ-017 MERGE: SHALL compute f = P(captured sbox_out) using the standard DES P table, then L<=R, R<=L xor f, round<=round+1.
REQ-018 After MERGE, round-counter transition 15->0 (16th round done) SHALL go to FINISH; otherwise ISSUE.
REQ-019 FINISH: preout SHALL equal {R, L} (final swap undone), done=1 for one cycle, busy<=0, next IDLE.
REQ-020 Round latency SHALL be 3 cycles (ISSUE, WAIT, MERGE); start to done SHALL be 49 cycles without re-issues.
REQ-021 preout SHALL hold its value until the next FINISH.
REQ-022 r_cur SHALL equal R continuously; it SHALL be stable throughout ISSUE and WAIT.

Reset
REQ-023 rst_n low SHALL asynchronously force state IDLE, L=R=0, round=0, preout=0, sbox_select=0, busy=0, done=0.
REQ-024 Reset asserted mid-round SHALL abandon the operation; no done pulse SHALL follow.
REQ-025 First start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-026 Macro DES_MERGE_PIPE_EN defined: a register SHALL hold P(sbox_out) between WAIT and MERGE (state PERM inserted), making round latency 4 and start-to-done 65 cycles.
REQ-027 Macro undefined: P permutation and XOR SHALL be combinational within MERGE, with latency per REQ-020.

Structure
REQ-028 Package des_pkg SHALL hold the P-table constant, the FSM state enum, and DES_ROUNDS = 16.
REQ-029 The P permutation SHALL be a combinational sub-module des_p_perm (32 in, 32 out).

Verification
REQ-030 Round 1 (key 133457799BBCDFF1, pt 0123456789ABCDEF): start with L0=CC00CCFF, R0=F0AAF0AA; bench returns sbox_out=5C82B597 with all finish -> after MERGE r_cur=EF4A6544, round=1.
REQ-031 Full 16 rounds with the bench S-box model for the same vector -> done after 49 cycles, preout=0A4CD99543423234.
REQ-032 sbox_finish=8'hFE in the first WAIT -> sbox_select re-pulsed; round unchanged until all finish=8'hFF.
REQ-033 start pulsed during round 5 -> ignored; L/R, round and the final preout unaffected.
REQ-034 rst_n low during round 9 -> all outputs 0 immediately, no done; subsequent start runs normally.
REQ-035 DES_MERGE_PIPE_EN build, REQ-031 stimulus -> done at 65 cycles, identical preout.

Source files
------------

// File: rtl/des_pkg.sv
// Shared constants and FSM encoding for the DES round-merge datapath.
package des_pkg;

  localparam int DES_ROUNDS = 16;
  localparam logic [3:0] LAST_ROUND = 4'(DES_ROUNDS - 1);

  // DES P permutation; entry [31] is output bit 1, values are 1-based DES input bit numbers.
  localparam logic [31:0][5:0] P_TABLE = {
    6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
    6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
    6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
    6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
  };

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_PERM   = 3'd3,
    ST_MERGE  = 3'd4,
    ST_FINISH = 3'd5
  } state_e;

endpackage

// File: rtl/des_p_perm.sv
// Combinational DES P permutation (DES bit 1 is the MSB of each word).
module des_p_perm
  import des_pkg::*;
(
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  for (genvar k = 0; k < 32; k++) begin : g_bit
    localparam int SRC = 32 - int'(P_TABLE[31-k]);
    assign data_o[31-k] = data_i[SRC];
  end

endmodule

// File: rtl/des_round_merge.sv
// DES Feistel round sequencer: issues S-box lookups, merges P(f) into L/R for 16 rounds.
// Define DES_MERGE_PIPE_EN to register P(sbox_out) in an extra PERM state (4-cycle rounds).
module des_round_merge
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] l_in,
  input  logic [31:0] r_in,
  input  logic [31:0] sbox_out,
  input  logic [7:0]  sbox_finish,
  output logic        sbox_select,
  output logic [31:0] r_cur,
  output logic [3:0]  round,
  output logic [63:0] preout,
  output logic        busy,
  output logic        done
);

  state_e      state_q, state_d;
  logic [31:0] l_q, l_d;
  logic [31:0] r_q, r_d;
  logic [3:0]  round_q, round_d;
  logic [31:0] sbox_q, sbox_d;
  logic [63:0] preout_q, preout_d;
  logic        sel_q, sel_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] p_s;
  logic [31:0] f_s;

  des_p_perm u_p_perm (
    .data_i (sbox_q),
    .data_o (p_s)
  );

`ifdef DES_MERGE_PIPE_EN
  logic [31:0] f_q, f_d;
  assign f_s = f_q;
`else
  assign f_s = p_s;
`endif

  always_comb begin
    state_d  = state_q;
    l_d      = l_q;
    r_d      = r_q;
    round_d  = round_q;
    sbox_d   = sbox_q;
    preout_d = preout_q;
    busy_d   = busy_q;
`ifdef DES_MERGE_PIPE_EN
    f_d      = f_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          l_d     = l_in;
          r_d     = r_in;
          round_d = 4'd0;
          busy_d  = 1'b1;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      // Any missing finish flag means the lookup is retried from ISSUE.
      ST_WAIT: begin
        if (&sbox_finish) begin
          sbox_d = sbox_out;
`ifdef DES_MERGE_PIPE_EN
          state_d = ST_PERM;
`else
          state_d = ST_MERGE;
`endif
        end else begin
          state_d = ST_ISSUE;
        end
      end
`ifdef DES_MERGE_PIPE_EN
      ST_PERM: begin
        f_d     = p_s;
        state_d = ST_MERGE;
      end
`endif
      ST_MERGE: begin
        l_d     = r_q;
        r_d     = l_q ^ f_s;
        round_d = round_q + 4'd1;
        if (round_q == LAST_ROUND) begin
          // Final swap undone: preout is {R16, L16}.
          preout_d = {l_q ^ f_s, r_q};
          state_d  = ST_FINISH;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_FINISH: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    sel_d  = (state_d == ST_ISSUE);
    done_d = (state_d == ST_FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      l_q      <= 32'h0;
      r_q      <= 32'h0;
      round_q  <= 4'd0;
      sbox_q   <= 32'h0;
      preout_q <= 64'h0;
      sel_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef DES_MERGE_PIPE_EN
      f_q      <= 32'h0;
`endif
    end else begin
      state_q  <= state_d;
      l_q      <= l_d;
      r_q      <= r_d;
      round_q  <= round_d;
      sbox_q   <= sbox_d;
      preout_q <= preout_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef DES_MERGE_PIPE_EN
      f_q      <= f_d;
`endif
    end
  end

  assign sbox_select = sel_q;
  assign r_cur       = r_q;
  assign round       = round_q;
  assign preout      = preout_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
